// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with NRD combinational
// read ports, two synchronous write ports (A and B, B has priority), optional
// same-cycle write-to-read bypass, optional hardwired-zero x0 and a per-register
// busy scoreboard with a registered busy count.
module register_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    output logic [AW:0]         busy_cnt
);

    // An address is usable when it maps onto a real register and is not the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !(ZERO_REG && (a == '0));
    endfunction

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    logic wa_ok;
    logic wb_ok;
    logic issue_ok;

    assign wa_ok    = wa_en && addr_ok(wa_addr);
    assign wb_ok    = wb_en && addr_ok(wb_addr);
    assign issue_ok = issue_en && addr_ok(issue_addr);

    // Next busy vector: writes retire producers, an issue installs a new one
    // and therefore overrides a same-cycle write to the same register.
    always_comb begin
        busy_d = busy_q;
        if (wa_ok) begin
            busy_d[wa_addr] = 1'b0;
        end
        if (wb_ok) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    // Popcount of the next busy vector so busy_cnt tracks busy_q edge for edge.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // Storage, scoreboard and count; port B is written last so it wins on a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wa_ok) begin
                regs_q[wa_addr] <= wa_data;
            end
            if (wb_ok) begin
                regs_q[wb_addr] <= wb_data;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   a;
        logic            ok;
        logic            wa_hit;
        logic            wb_hit;
        logic            is_hit;
        logic [XLEN-1:0] d;
        logic            b;

        assign a      = rd_addr[gi*AW +: AW];
        assign ok     = addr_ok(a);
        assign wa_hit = BYPASS && wa_ok && (wa_addr == a);
        assign wb_hit = BYPASS && wb_ok && (wb_addr == a);
        assign is_hit = issue_ok && (issue_addr == a);

        // Read mux: storage first, then bypass A, then bypass B (B has priority).
        // A bypassed write clears busy unless a new producer issues this cycle.
        always_comb begin
            d = ok ? regs_q[a] : '0;
            b = ok ? busy_q[a] : 1'b0;
            if (wa_hit) begin
                d = wa_data;
            end
            if (wb_hit) begin
                d = wb_data;
            end
            if ((wa_hit || wb_hit) && !is_hit) begin
                b = 1'b0;
            end
        end

        assign rd_data[gi*XLEN +: XLEN] = d;
        assign rd_busy[gi]              = b;
    end

endmodule
